// File: rtl/graphics_pkg.sv
// Shared display constants: RGB332 palette, active-area limits, pixel type.
// No logic; imported by the compositor datapath.
package graphics_pkg;

  localparam int COLOR_W  = 8;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef logic [COLOR_W-1:0] pixel_t;

  localparam pixel_t BLK = 8'h00;
  localparam pixel_t RED = 8'hE0;
  localparam pixel_t PNK = 8'hF3;
  localparam pixel_t CYN = 8'h1F;
  localparam pixel_t ORG = 8'hF4;
  localparam pixel_t YLW = 8'hFC;
  localparam pixel_t WHT = 8'hFF;
  localparam pixel_t CRM = 8'hFE;
  localparam pixel_t BLU = 8'h03;

endpackage

// File: rtl/sprite_priority_mux.sv
// Picks the lowest-index enabled opaque sprite, else the maze colour.
// Latency: combinational. Backpressure: none.
module sprite_priority_mux #(
  parameter int NUM_SPRITES = 5,
  parameter int COLOR_W     = 8
) (
  input  logic [NUM_SPRITES*COLOR_W-1:0] spr_color,
  input  logic [NUM_SPRITES-1:0]         spr_en,
  input  logic [COLOR_W-1:0]             maze_color,
  output logic [COLOR_W-1:0]             color
);

  // Walk from lowest priority upward so channel 0 overrides last.
  always_comb begin
    color = maze_color;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (spr_en[i] && (spr_color[i*COLOR_W +: COLOR_W] != '0)) begin
        color = spr_color[i*COLOR_W +: COLOR_W];
      end
    end
  end

endmodule

// File: rtl/sprite_compositor.sv
// Rotated-playfield sprite compositor with per-frame collision vector (SPRITE_COLLISION_EN).
// Latency: coords/address 1 clk, colour/de 3 clk after hc/vc. Backpressure: none (free-running).
module sprite_compositor
  import graphics_pkg::*;
#(
  parameter int NUM_SPRITES = 5,
  parameter int COLOR_W     = 8,
  parameter int XMAX        = 240,
  parameter int YMAX        = 320,
  parameter int YOFFSET     = 24,
  parameter int ROW_STRIDE  = 264,
  parameter int ADDR_W      = 16,
  parameter int PAC_IDX     = NUM_SPRITES - 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [9:0]                     hc,
  input  logic [9:0]                     vc,
  input  logic [NUM_SPRITES-1:0]         spr_en,
  input  logic [NUM_SPRITES*COLOR_W-1:0] spr_color,
  input  logic [COLOR_W-1:0]             maze_color,
  output logic [8:0]                     xpos,
  output logic [8:0]                     ypos,
  output logic [ADDR_W-1:0]              address,
  output logic [COLOR_W-1:0]             color,
  output logic                           de,
  output logic [NUM_SPRITES-1:0]         collision,
  output logic                           collision_valid
);

  logic              h_act, v_act, frame_start;
  logic [8:0]        x_nxt, y_nxt;
  logic [31:0]       y_wide;
  logic [ADDR_W-1:0] addr_nxt;

  logic                           act1, act2;
  logic [NUM_SPRITES-1:0]         shadow_en, en1, en2;
  logic [NUM_SPRITES*COLOR_W-1:0] spr2;
  logic [COLOR_W-1:0]             mux_color;

  assign h_act       = hc < 10'(H_ACTIVE);
  assign v_act       = vc < 10'(V_ACTIVE);
  assign frame_start = (hc == '0) && (vc == '0);

  // Screen is rotated: scanlines map to playfield columns, right to left.
  always_comb begin
    x_nxt = '0;
    y_nxt = '0;
    if (v_act) begin
      x_nxt = 9'(XMAX - 1) - vc[9:1];
      y_nxt = h_act ? hc[9:1] : 9'(YMAX - 1);
    end
  end

  assign y_wide   = 32'(y_nxt);
  assign addr_nxt = (y_wide >= 32'(YOFFSET) && y_wide < 32'(YOFFSET + ROW_STRIDE))
                  ? ADDR_W'(x_nxt) * ADDR_W'(ROW_STRIDE) + ADDR_W'(y_nxt) - ADDR_W'(YOFFSET)
                  : '1;

  sprite_priority_mux #(
    .NUM_SPRITES (NUM_SPRITES),
    .COLOR_W     (COLOR_W)
  ) u_mux (
    .spr_color  (spr2),
    .spr_en     (en2),
    .maze_color (maze_color),
    .color      (mux_color)
  );

  // Enables travel with each pixel so the frame-start pixel already sees the new shadow
  // and the previous frame's tail never does.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xpos      <= '0;
      ypos      <= '0;
      address   <= '1;
      act1      <= 1'b0;
      en1       <= '0;
      shadow_en <= '0;
      spr2      <= '0;
      act2      <= 1'b0;
      en2       <= '0;
      color     <= '0;
      de        <= 1'b0;
    end else begin
      xpos    <= x_nxt;
      ypos    <= y_nxt;
      address <= addr_nxt;
      act1    <= h_act && v_act;
      en1     <= frame_start ? spr_en : shadow_en;
      if (frame_start) begin
        shadow_en <= spr_en;
      end
      spr2  <= spr_color;
      act2  <= act1;
      en2   <= en1;
      color <= act2 ? mux_color : '0;
      de    <= act2;
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic                   end1, end2;
  logic [NUM_SPRITES-1:0] opaque, hits, acc;

  always_comb begin
    opaque = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      opaque[i] = en2[i] && (spr2[i*COLOR_W +: COLOR_W] != '0);
    end
    hits          = (act2 && opaque[PAC_IDX]) ? opaque : '0;
    hits[PAC_IDX] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      end1            <= 1'b0;
      end2            <= 1'b0;
      acc             <= '0;
      collision       <= '0;
      collision_valid <= 1'b0;
    end else begin
      end1 <= (hc == 10'(H_ACTIVE - 1)) && (vc == 10'(V_ACTIVE - 1));
      end2 <= end1;
      // Final active pixel's own hits are folded into the reported vector.
      if (end2) begin
        collision       <= acc | hits;
        collision_valid <= 1'b1;
        acc             <= '0;
      end else begin
        collision_valid <= 1'b0;
        acc             <= acc | hits;
      end
    end
  end
`else
  assign collision       = '0;
  assign collision_valid = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Randomised + directed bench for sprite_compositor against a per-pixel behavioural model.
module tb_sprite_compositor;

  localparam int NS  = 5;
  localparam int CW  = 8;
  localparam int PAC = NS - 1;
  localparam int NE  = 8192;
`ifdef SPRITE_COLLISION_EN
  localparam bit COLL_ON = 1'b1;
`else
  localparam bit COLL_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [9:0]     hc = '0, vc = '0;
  logic [NS-1:0]  spr_en = '0;
  logic [NS*CW-1:0] spr_color = '0;
  logic [CW-1:0]  maze_color = '0;
  logic [8:0]     xpos, ypos;
  logic [15:0]    address;
  logic [CW-1:0]  color;
  logic           de;
  logic [NS-1:0]  collision;
  logic           collision_valid;

  sprite_compositor dut (
    .clk             (clk),
    .rst             (rst),
    .hc              (hc),
    .vc              (vc),
    .spr_en          (spr_en),
    .spr_color       (spr_color),
    .maze_color      (maze_color),
    .xpos            (xpos),
    .ypos            (ypos),
    .address         (address),
    .color           (color),
    .de              (de),
    .collision       (collision),
    .collision_valid (collision_valid)
  );

  always #5 clk = ~clk;

  // Per-edge stimulus record: pixel sampled at edge e.
  int      s_hc [NE];
  int      s_vc [NE];
  bit [4:0]  s_en [NE];
  bit [39:0] s_sc [NE];
  bit [7:0]  s_mz [NE];
  bit      live [NE];
  int      epoch [NE];
  int      lit_x [NE], lit_y [NE], lit_a [NE], lit_c [NE], lit_de [NE], lit_co [NE];
  int      cur_epoch = 0;
  int      ecount = 0;
  int      n_chk = 0;
  int      n_pass = 0;
  bit [4:0] m_sh = '0, m_acc = '0, m_coll = '0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s edge %0d: got %0h expected %0h", nm, ecount - 1, act, exp);
  endtask

  function automatic int mod_x(input int h, input int v);
    return (v < 480) ? 239 - v / 2 : 0;
  endfunction

  function automatic int mod_y(input int h, input int v);
    if (v >= 480) return 0;
    return (h < 640) ? h / 2 : 319;
  endfunction

  function automatic int mod_addr(input int x, input int y);
    if (y >= 24 && y < 24 + 264) return (x * 264 + y - 24) % 65536;
    return 65535;
  endfunction

  // Compare process: checks every edge, 1ns after it.
  always @(posedge clk) begin
    int e, k;
    bit [7:0] ec, cc;
    bit ede, ev, found;
    e = ecount;
    ecount++;
    #1;
    if (!rst) begin
      chk("rst_xpos", xpos, 0);
      chk("rst_ypos", ypos, 0);
      chk("rst_address", address, 16'hFFFF);
      chk("rst_color", color, 0);
      chk("rst_de", de, 0);
      chk("rst_collision", collision, 0);
      chk("rst_collision_valid", collision_valid, 0);
      m_sh = '0; m_acc = '0; m_coll = '0;
    end else begin
      if (live[e]) begin
        chk("xpos", xpos, mod_x(s_hc[e], s_vc[e]));
        chk("ypos", ypos, mod_y(s_hc[e], s_vc[e]));
        chk("address", address, mod_addr(mod_x(s_hc[e], s_vc[e]), mod_y(s_hc[e], s_vc[e])));
        if (lit_x[e] >= 0) chk("lit_xpos", xpos, lit_x[e]);
        if (lit_y[e] >= 0) chk("lit_ypos", ypos, lit_y[e]);
        if (lit_a[e] >= 0) chk("lit_address", address, lit_a[e]);
      end
      k = e - 2;
      ec = 0; ede = 0; ev = 0;
      if (k >= 0 && live[k] && epoch[k] == cur_epoch) begin
        if (s_hc[k] == 0 && s_vc[k] == 0) m_sh = s_en[k];
        if (s_hc[k] < 640 && s_vc[k] < 480) begin
          ede = 1;
          ec = s_mz[k];
          found = 0;
          for (int i = 0; i < NS; i++) begin
            cc = s_sc[k][i*8 +: 8];
            if (!found && m_sh[i] && cc != 0) begin
              ec = cc;
              found = 1;
            end
          end
          if (COLL_ON && m_sh[PAC] && s_sc[k][PAC*8 +: 8] != 0) begin
            for (int i = 0; i < NS; i++)
              if (i != PAC && m_sh[i] && s_sc[k][i*8 +: 8] != 0) m_acc[i] = 1'b1;
          end
        end
        if (COLL_ON && s_hc[k] == 639 && s_vc[k] == 479) begin
          m_coll = m_acc;
          m_acc = '0;
          ev = 1;
        end
      end
      chk("color", color, ec);
      chk("de", de, ede);
      chk("collision", collision, m_coll);
      chk("collision_valid", collision_valid, ev);
      if (lit_c[e] >= 0)  chk("lit_color", color, lit_c[e]);
      if (lit_de[e] >= 0) chk("lit_de", de, lit_de[e]);
      if (lit_co[e] >= 0) chk("lit_collision", collision, lit_co[e]);
    end
  end

  // Drive one pixel; its sprite colours follow one cycle later, maze data two.
  task automatic pix(input int h, input int v, input bit [4:0] en, input bit [39:0] sc,
                     input bit [7:0] mz, input bit r,
                     input int lx = -1, input int ly = -1, input int la = -1,
                     input int lc = -1, input int lde = -1, input int lco = -1);
    int i;
    @(negedge clk);
    if (!r && rst) cur_epoch++;
    rst = r;
    i = ecount;
    s_hc[i] = h; s_vc[i] = v; s_en[i] = en; s_sc[i] = sc; s_mz[i] = mz;
    live[i] = r; epoch[i] = cur_epoch;
    lit_x[i] = lx; lit_y[i] = ly; lit_a[i] = la;
    if (i + 2 < NE) begin
      lit_c[i+2] = lc; lit_de[i+2] = lde; lit_co[i+2] = lco;
    end
    hc = 10'(h);
    vc = 10'(v);
    spr_en = en;
    spr_color = (i >= 1) ? s_sc[i-1] : '0;
    maze_color = (i >= 2) ? s_mz[i-2] : '0;
  endtask

  function automatic bit [39:0] rnd_sc();
    bit [39:0] s;
    s = '0;
    for (int i = 0; i < NS; i++)
      if ($urandom_range(0, 1) == 1) s[i*8 +: 8] = 8'($urandom_range(1, 255));
    return s;
  endfunction

  initial begin
    int h, v;
    for (int i = 0; i < NE; i++) begin
      lit_x[i] = -1; lit_y[i] = -1; lit_a[i] = -1;
      lit_c[i] = -1; lit_de[i] = -1; lit_co[i] = -1;
    end
    #1 rst = 1'b0;
    repeat (3) pix(700, 500, 5'h1F, rnd_sc(), 8'h5A, 0);

    // Coordinate / address anchors
    pix(100, 50, 5'($urandom), rnd_sc(), 8'($urandom), 1, 214, 50, 56522);
    pix(10, 50, 5'($urandom), rnd_sc(), 8'($urandom), 1, -1, -1, 65535);

    // Frame 1: all channels on, priority, maze fallback, blanking, one pac/ch2 hit
    pix(0, 0, 5'h1F, '0, 8'h00, 1);
    pix(20, 20, 5'($urandom), {8'h00, 8'h00, 8'h00, 8'hEF, 8'hE0}, 8'h03, 1, -1, -1, -1, 8'hE0, 1);
    pix(22, 20, 5'($urandom), '0, 8'h03, 1, -1, -1, -1, 8'h03, 1);
    pix(30, 481, 5'($urandom), {5{8'hFF}}, 8'h03, 1, -1, -1, -1, 0, 0);
    pix(200, 100, 5'($urandom), {8'h1F, 8'h00, 8'hFC, 8'h00, 8'h00}, 8'h03, 1, -1, -1, -1, 8'hFC, 1);
    pix(639, 479, 5'($urandom), {8'h00, 8'h00, 8'h00, 8'h00, 8'hE0}, 8'h00, 1,
        -1, -1, -1, 8'hE0, 1, COLL_ON ? 5'b00100 : 0);
    repeat (3) pix(700, 500, 5'($urandom), rnd_sc(), 8'($urandom), 1);

    // Frame 2: ch0 disabled at frame start, spr_en toggles mid-frame
    pix(0, 0, 5'b11110, '0, 8'h00, 1);
    pix(20, 20, 5'h1F, {8'h00, 8'h00, 8'h00, 8'hEF, 8'hE0}, 8'h03, 1, -1, -1, -1, 8'hEF, 1);
    repeat (6) pix($urandom_range(0, 639), $urandom_range(0, 479), 5'($urandom),
                   {24'h0, 8'hEF, 8'hE0}, 8'h03, 1);
    pix(300, 200, 5'h1F, {32'h0, 8'hE0}, 8'h03, 1, -1, -1, -1, 8'h03, 1);
    pix(639, 479, 5'h1F, '0, 8'h00, 1, -1, -1, -1, 0, 1, 0);

    // Frame 3: overlap only on the final active pixel
    pix(0, 0, 5'h1F, '0, 8'h00, 1);
    pix(639, 479, 5'($urandom), {8'h1F, 8'h00, 8'h00, 8'hEF, 8'h00}, 8'h00, 1,
        -1, -1, -1, 8'hEF, 1, COLL_ON ? 5'b00010 : 0);

    // Frame 4: hit, then reset mid-frame; next strobe must be clean
    pix(0, 0, 5'h1F, '0, 8'h00, 1);
    pix(50, 60, 5'($urandom), {8'h1F, 8'hFC, 24'h0}, 8'h00, 1);
    pix(700, 10, 5'($urandom), '0, 8'h00, 1);
    repeat (2) pix(52, 60, 5'h1F, {8'h1F, 8'hFC, 24'h0}, 8'h00, 0);
    pix(0, 0, 5'h1F, '0, 8'h00, 1);
    pix(10, 10, 5'($urandom), {8'h1F, 32'h0}, 8'h00, 1);
    pix(639, 479, 5'($urandom), '0, 8'h00, 1, -1, -1, -1, -1, -1, 0);

    // Random frames, one with a mid-frame reset
    for (int f = 0; f < 6; f++) begin
      pix(0, 0, 5'($urandom), rnd_sc(), 8'($urandom), 1);
      for (int n = 0; n < 300; n++) begin
        h = $urandom_range(0, 799);
        v = $urandom_range(0, 524);
        if ($urandom_range(0, 7) == 0) h = 638 + $urandom_range(0, 3);
        if ($urandom_range(0, 7) == 0) v = 478 + $urandom_range(0, 3);
        pix(h, v, 5'($urandom), rnd_sc(), 8'($urandom), !(f == 3 && n == 150));
      end
      pix(639, 479, 5'($urandom), rnd_sc(), 8'($urandom), 1);
    end

    repeat (4) pix(700, 500, '0, '0, 8'h00, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sprite_compositor.md
SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 5, meaning sprite channel count with index 0 highest priority.
REQ-002 SHALL have parameter COLOR_W, default 8, meaning RGB332 colour width.
REQ-003 SHALL have parameters XMAX 240, YMAX 320, YOFFSET 24, ROW_STRIDE 264, ADDR_W 16, meaning the rotated playfield size, first RAM-backed row, RAM row pitch and address width.
REQ-004 SHALL have parameter PAC_IDX, default NUM_SPRITES-1, meaning the channel tested against all others for collision.
REQ-005 Port: clk  in  1  single clock; all state on rising edge.
REQ-006 Port: rst  in  1  reset, asynchronous and active-low.
REQ-007 Port: hc, vc  in  10 each  VGA counters, active area hc<640, vc<480.
REQ-008 Port: spr_en  in  NUM_SPRITES  per-channel enable request.
REQ-009 Port: spr_color  in  NUM_SPRITES*COLOR_W  packed sprite colours, channel i at [i*COLOR_W +: COLOR_W], 0 = transparent.
REQ-010 Port: maze_color  in  COLOR_W  maze RAM read data, one-cycle read latency.
REQ-011 Port: xpos, ypos  out  9 each  registered rotated playfield coordinates driven to sprite renderers.
REQ-012 Port: address  out  ADDR_W  registered maze RAM address.
REQ-013 Port: color, de  out  COLOR_W, 1  registered composited pixel and display enable.
REQ-014 Port: collision, collision_valid  out  NUM_SPRITES, 1  per-frame collision vector and one-cycle strobe.

Function
REQ-015 Stage 1 (hc/vc sampled at cycle N) SHALL register xpos=XMAX-1-(vc>>1), ypos=hc>>1, valid N+1, when hc<640 and vc<480.
REQ-016 For hc>=640 with vc<480, stage 1 SHALL register ypos=YMAX-1 and xpos=XMAX-1-(vc>>1); for vc>=480 it SHALL register xpos=ypos=0.
REQ-017 Stage 1 SHALL register address=xpos*ROW_STRIDE+(ypos-YOFFSET) when YOFFSET<=ypos<YOFFSET+ROW_STRIDE, else all-ones; arithmetic SHALL be ADDR_W wide, truncating.
REQ-018 Stage 2 SHALL register spr_color and the active flag at N+2; maze_color SHALL be consumed at N+2 unregistered.
REQ-019 Stage 3 SHALL register color and de at N+3: first enabled channel with non-zero colour by ascending index, else maze_color, else 0.
REQ-020 color SHALL be 0 and de SHALL be 0 whenever the pixel's sampled hc/vc was outside the active area.
REQ-021 spr_en SHALL be captured into a shadow register when hc==0 and vc==0 at the input; the shadow SHALL govern the entire frame, and a disabled channel SHALL be treated as transparent.
REQ-022 Collision: at stage 3 with de, if channel PAC_IDX is opaque and enabled, each other opaque enabled channel i SHALL set sticky accumulator bit i.
REQ-023 When the stage-3 pixel originates from hc==639, vc==479, collision SHALL load the accumulator including that pixel's hits, collision_valid SHALL pulse one cycle, and the accumulator SHALL clear.
REQ-024 Bit PAC_IDX of collision SHALL always be 0; NUM_SPRITES=1 SHALL yield collision permanently 0.

Reset
REQ-025 While rst is low, all pipeline registers, shadow enables and the accumulator SHALL be 0, address SHALL be all-ones, and collision_valid SHALL be 0.
REQ-026 Reset asserted mid-frame SHALL discard that frame's partial collision data; the first strobe after release SHALL cover only post-reset pixels.

Configuration
REQ-027 Macro SPRITE_COLLISION_EN defined: REQ-022..024 are implemented.
REQ-028 Macro SPRITE_COLLISION_EN undefined: no accumulator is built, collision and collision_valid are tied to 0, and colour behaviour is unchanged.

Structure
REQ-029 The colour constants (BLK, RED, PNK, CYN, ORG, YLW, WHT, CRM, BLU), the active-area limits 640/480, and the pixel_t COLOR_W typedef SHALL live in package graphics_pkg.
REQ-030 The priority mux SHALL be sub-module sprite_priority_mux (combinational, parameterised by NUM_SPRITES/COLOR_W); the pipeline and collision logic stay in the top.

Verification
REQ-031 hc=100, vc=50 -> after 1 clk: xpos=214, ypos=50, address=214*264+26=56522; hc=10 -> address=0xFFFF.
REQ-032 ch0=0xE0 and ch1=0xEF both opaque, maze=0x03 -> color=0xE0 at N+3; ch0 disabled at frame start -> color=0xEF for the whole frame, even if spr_en toggles mid-frame.
REQ-033 All channels 0, maze_color=0x03 -> color=0x03 with de=1; vc=481 -> color=0, de=0.
REQ-034 Channel 4 (PAC_IDX) and channel 2 opaque at one pixel -> collision=5'b00100 with a single collision_valid pulse 3 clk after hc=639/vc=479; the next frame with no overlap -> collision=0.
REQ-035 Overlap only on the final active pixel -> the hit is included in that frame's vector.
REQ-036 rst low mid-frame after a hit -> the next strobe reports 0; with SPRITE_COLLISION_EN undefined, collision_valid never asserts.
